// File: rtl/pulse_sim_pkg.sv
// Shared definitions for the pulse simulator: FSM encoding, latched
// configuration record, saturation limits, LFSR constants and the 16-bit
// saturating helper used by every output channel.
package pulse_sim_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int ADC_DATA_WIDTH_DEF = 16;

  localparam logic signed [15:0] SAT_MAX = 16'sh7FFF;
  localparam logic signed [15:0] SAT_MIN = 16'sh8000;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Galois (right-shift) mask for x^16 + x^14 + x^13 + x^11 + 1
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Configuration snapshot taken at sequence start
  typedef struct packed {
    logic signed [15:0] baseline;
    logic signed [15:0] amp_a;
    logic signed [15:0] amp_b;
    logic signed [15:0] amp_c;
    logic [15:0]        delay_ab;
    logic [15:0]        delay_bc;
    logic [15:0]        width;
    logic [31:0]        period;   // already clamped to >= 1
    logic               rep;
  } cfg_t;

  // Clamp an 18-bit signed sum into the signed 16-bit sample range
  function automatic logic signed [15:0] sat16(input logic signed [17:0] v);
    if (v > 18'sd32767)  return SAT_MAX;
    if (v < -18'sd32768) return SAT_MIN;
    return v[15:0];
  endfunction

endpackage

// File: rtl/pulse_sim_gen_if.sv
// ADC-style output bus of the pulse simulator.
//   adc_data_a..d   : {sample1, sample0}, sample0 earlier in time
//   adc_enable_a..d : channel enable
//   adc_valid_a..d  : channel data valid
//   seq_active      : high while a sequence is running
//   seq_count       : completed-sequence counter
// master = generator side, slave = consumer side.
interface pulse_sim_gen_if
  import pulse_sim_pkg::*;
#(
  parameter int W = ADC_DATA_WIDTH_DEF
);
  logic [2*W-1:0] adc_data_a, adc_data_b, adc_data_c, adc_data_d;
  logic           adc_enable_a, adc_enable_b, adc_enable_c, adc_enable_d;
  logic           adc_valid_a, adc_valid_b, adc_valid_c, adc_valid_d;
  logic           seq_active;
  logic [31:0]    seq_count;

  modport master (
    output adc_data_a, adc_data_b, adc_data_c, adc_data_d,
    output adc_enable_a, adc_enable_b, adc_enable_c, adc_enable_d,
    output adc_valid_a, adc_valid_b, adc_valid_c, adc_valid_d,
    output seq_active, seq_count
  );

  modport slave (
    input adc_data_a, adc_data_b, adc_data_c, adc_data_d,
    input adc_enable_a, adc_enable_b, adc_enable_c, adc_enable_d,
    input adc_valid_a, adc_valid_b, adc_valid_c, adc_valid_d,
    input seq_active, seq_count
  );
endinterface

// File: rtl/pulse_sim_sample.sv
// One output sample: half-open window test on the sample index followed by
// a saturating add of baseline, optional pulse amplitude and noise.
//   idx_i    : absolute sample index within the sequence (2k or 2k+1)
//   win_lo_i : first sample inside the pulse window
//   win_hi_i : first sample after the pulse window
//   base_i   : idle level
//   amp_i    : pulse offset applied inside the window
//   noise_i  : additive noise (zero when noise is not built in)
//   sample_o : saturated sample
module pulse_sim_sample
  import pulse_sim_pkg::*;
(
  input  logic [32:0]        idx_i,
  input  logic [17:0]        win_lo_i,
  input  logic [17:0]        win_hi_i,
  input  logic signed [15:0] base_i,
  input  logic signed [15:0] amp_i,
  input  logic signed [15:0] noise_i,
  output logic signed [15:0] sample_o
);
  logic              in_win;
  logic signed [17:0] sum;

  // Bounds are zero-extended so large word counts never alias into a window
  assign in_win = (idx_i >= {15'd0, win_lo_i}) && (idx_i < {15'd0, win_hi_i});

  assign sum = $signed({{2{base_i[15]}}, base_i})
             + (in_win ? $signed({{2{amp_i[15]}}, amp_i}) : 18'sd0)
             + $signed({{2{noise_i[15]}}, noise_i});

  assign sample_o = sat16(sum);
endmodule

// File: rtl/pulse_sim_gen.sv
// Pulse simulator: emits two samples per clock on four ADC-like channels.
// Channels a-c carry a rectangular pulse (width samples) on top of the
// baseline, staggered by delay_ab / delay_bc; channel d carries baseline only.
// Sequences are period_words clocks long, single shot or repeating.
// Optional build macro: PULSE_SIM_NOISE_EN adds 4-bit LFSR noise per sample.
// Ports:
//   clk, rst                : clock, synchronous active-high reset
//   sim_enable, sim_repeat  : run request (level), periodic mode
//   baseline, amp_a..amp_c  : signed levels
//   delay_ab, delay_bc      : pulse start spacing in samples
//   width, period_words     : pulse length (samples), sequence length (clocks)
//   adc                     : output bus (pulse_sim_gen_if.master)
module pulse_sim_gen
  import pulse_sim_pkg::*;
#(
  parameter int ADC_DATA_WIDTH = ADC_DATA_WIDTH_DEF
)(
  input  logic               clk,
  input  logic               rst,
  input  logic               sim_enable,
  input  logic               sim_repeat,
  input  logic signed [15:0] baseline,
  input  logic signed [15:0] amp_a,
  input  logic signed [15:0] amp_b,
  input  logic signed [15:0] amp_c,
  input  logic [15:0]        delay_ab,
  input  logic [15:0]        delay_bc,
  input  logic [15:0]        width,
  input  logic [31:0]        period_words,
  pulse_sim_gen_if.master    adc
);
  state_t      state_q, state_d;
  logic [31:0] k_q, k_d;
  logic [31:0] seq_cnt_q, seq_cnt_d;
  cfg_t        cfg_q, cfg_d, cfg_live;
  logic        vld_q;
  logic [2*ADC_DATA_WIDTH-1:0] data_q [4];

  logic               run;
  logic signed [15:0] base_cur;
  logic signed [15:0] amp_cfg [3];
  logic [17:0]        win_lo [3];
  logic [17:0]        win_hi [3];
  logic signed [15:0] noise [2];
  logic signed [15:0] smp [3][2];
  logic signed [15:0] smp_d [2];

  function automatic logic signed [ADC_DATA_WIDTH-1:0] ext(input logic signed [15:0] s);
    return ADC_DATA_WIDTH'(s);
  endfunction

  assign cfg_live = '{baseline: baseline, amp_a: amp_a, amp_b: amp_b, amp_c: amp_c,
                      delay_ab: delay_ab, delay_bc: delay_bc, width: width,
                      period: (period_words == 32'd0) ? 32'd1 : period_words,
                      rep: sim_repeat};

  // Sequencing: abort on enable drop wins over the word-end decision
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    seq_cnt_d = seq_cnt_q;
    cfg_d     = cfg_q;
    unique case (state_q)
      IDLE: if (sim_enable) begin
        state_d = RUN;
        k_d     = 32'd0;
        cfg_d   = cfg_live;
      end
      RUN: begin
        if (!sim_enable) begin
          state_d = IDLE;
          k_d     = 32'd0;
        end else if (k_q == cfg_q.period - 32'd1) begin
          seq_cnt_d = seq_cnt_q + 32'd1;
          k_d       = 32'd0;
          if (cfg_q.rep) cfg_d = cfg_live;
          else           state_d = DONE;
        end else begin
          k_d = k_q + 32'd1;
        end
      end
      DONE: if (!sim_enable) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outside RUN the amplitudes are forced to zero and the live baseline shows
  assign run        = (state_q == RUN);
  assign base_cur   = run ? cfg_q.baseline : baseline;
  assign amp_cfg[0] = run ? cfg_q.amp_a : 16'sd0;
  assign amp_cfg[1] = run ? cfg_q.amp_b : 16'sd0;
  assign amp_cfg[2] = run ? cfg_q.amp_c : 16'sd0;

  // 18-bit window bounds: three 16-bit terms cannot overflow
  assign win_lo[0] = 18'd0;
  assign win_hi[0] = {2'b0, cfg_q.width};
  assign win_lo[1] = {2'b0, cfg_q.delay_ab};
  assign win_hi[1] = win_lo[1] + {2'b0, cfg_q.width};
  assign win_lo[2] = win_lo[1] + {2'b0, cfg_q.delay_bc};
  assign win_hi[2] = win_lo[2] + {2'b0, cfg_q.width};

`ifdef PULSE_SIM_NOISE_EN
  logic [15:0] lfsr_q, lfsr_mid;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
  endfunction

  // Two steps per clock: current value feeds sample0, one step on feeds sample1
  assign lfsr_mid = lfsr_step(lfsr_q);

  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= LFSR_SEED;
    else     lfsr_q <= lfsr_step(lfsr_mid);
  end

  assign noise[0] = {{12{lfsr_q[3]}}, lfsr_q[3:0]};
  assign noise[1] = {{12{lfsr_mid[3]}}, lfsr_mid[3:0]};
`else
  assign noise[0] = 16'sd0;
  assign noise[1] = 16'sd0;
`endif

  for (genvar ch = 0; ch < 3; ch++) begin : g_ch
    for (genvar j = 0; j < 2; j++) begin : g_smp
      pulse_sim_sample u_smp (
        .idx_i    ({k_q, 1'(j)}),
        .win_lo_i (win_lo[ch]),
        .win_hi_i (win_hi[ch]),
        .base_i   (base_cur),
        .amp_i    (amp_cfg[ch]),
        .noise_i  (noise[j]),
        .sample_o (smp[ch][j])
      );
    end
  end

  for (genvar j = 0; j < 2; j++) begin : g_d
    assign smp_d[j] = sat16($signed({{2{base_cur[15]}}, base_cur})
                          + $signed({{2{noise[j][15]}}, noise[j]}));
  end

  // Output register stage: one clock from counter state to adc_data
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      k_q       <= 32'd0;
      seq_cnt_q <= 32'd0;
      vld_q     <= 1'b0;
      for (int ch = 0; ch < 4; ch++) data_q[ch] <= '0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      seq_cnt_q <= seq_cnt_d;
      vld_q     <= 1'b1;
      for (int ch = 0; ch < 3; ch++) data_q[ch] <= {ext(smp[ch][1]), ext(smp[ch][0])};
      data_q[3] <= {ext(smp_d[1]), ext(smp_d[0])};
    end
  end

  always_ff @(posedge clk) begin
    cfg_q <= cfg_d;
  end

  assign adc.adc_data_a   = data_q[0];
  assign adc.adc_data_b   = data_q[1];
  assign adc.adc_data_c   = data_q[2];
  assign adc.adc_data_d   = data_q[3];
  assign adc.adc_enable_a = vld_q;
  assign adc.adc_enable_b = vld_q;
  assign adc.adc_enable_c = vld_q;
  assign adc.adc_enable_d = vld_q;
  assign adc.adc_valid_a  = vld_q;
  assign adc.adc_valid_b  = vld_q;
  assign adc.adc_valid_c  = vld_q;
  assign adc.adc_valid_d  = vld_q;
  assign adc.seq_active   = run;
  assign adc.seq_count    = seq_cnt_q;
endmodule
